// File: rtl/tft_timing_pkg.sv
// Shared timing constants and test-bar colour helpers for the 480x272 RGB565 TFT panel.
package tft_timing_pkg;

  localparam int H_SYNC_W  = 41;
  localparam int H_BACK_W  = 2;
  localparam int H_VALID_W = 480;
  localparam int H_FRONT_W = 2;
  localparam int V_SYNC_W  = 10;
  localparam int V_BACK_W  = 2;
  localparam int V_VALID_W = 272;
  localparam int V_FRONT_W = 2;

  localparam int H_TOTAL = H_SYNC_W + H_BACK_W + H_VALID_W + H_FRONT_W;
  localparam int V_TOTAL = V_SYNC_W + V_BACK_W + V_VALID_W + V_FRONT_W;

  localparam int BAR_WIDTH = 60;
  localparam int BAR_COUNT = 8;

  typedef enum logic [2:0] {
    BAR_WHITE,
    BAR_RED,
    BAR_GREEN,
    BAR_BLUE,
    BAR_YELLOW,
    BAR_MAGENTA,
    BAR_CYAN,
    BAR_BLACK
  } bar_e;

  function automatic logic [15:0] bar_color(input bar_e bar);
    logic [15:0] color;
    case (bar)
      BAR_WHITE:   color = 16'hFFFF;
      BAR_RED:     color = 16'hF800;
      BAR_GREEN:   color = 16'h07E0;
      BAR_BLUE:    color = 16'h001F;
      BAR_YELLOW:  color = 16'hFFE0;
      BAR_MAGENTA: color = 16'hF81F;
      BAR_CYAN:    color = 16'h07FF;
      default:     color = 16'h0000;
    endcase
    return color;
  endfunction

  // Threshold compare instead of a divide: column / BAR_WIDTH, saturating at the last bar.
  function automatic bar_e bar_index(input logic [10:0] col);
    bar_e idx;
    idx = BAR_WHITE;
    for (int i = 1; i < BAR_COUNT; i++) begin
      if (col >= 11'(i * BAR_WIDTH)) idx = bar_e'(3'(i));
    end
    return idx;
  endfunction

endpackage

// File: rtl/tft_test_pattern.sv
// Eight-bar colour lookup for the panel self-test, driven from the horizontal counter.
module tft_test_pattern
  import tft_timing_pkg::*;
#(
  parameter int H_START = H_SYNC_W + H_BACK_W
) (
  input  logic [10:0] cnt_h,
  output logic [15:0] bar_rgb
);

  logic [10:0] col;

  always_comb begin
    col     = cnt_h - 11'(H_START);
    bar_rgb = bar_color(bar_index(col));
  end

endmodule

// File: rtl/tft_timing_ctrl.sv
// Pixel-clock timing controller for the 480x272 TFT: sync/DE generation, latency-compensated
// pixel requests and registered RGB565 output. Optional bar pattern under TFT_TEST_PATTERN_EN.
module tft_timing_ctrl
  import tft_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_W,
  parameter int H_BACK  = H_BACK_W,
  parameter int H_VALID = H_VALID_W,
  parameter int H_FRONT = H_FRONT_W,
  parameter int V_SYNC  = V_SYNC_W,
  parameter int V_BACK  = V_BACK_W,
  parameter int V_VALID = V_VALID_W,
  parameter int V_FRONT = V_FRONT_W,
  parameter int PIX_LAT = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
`ifdef TFT_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  input  logic [15:0] pix_data,
  output logic        pix_req,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic [15:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        tft_de,
  output logic        tft_clk,
  output logic        tft_bl,
  output logic        frame_start
);

  localparam int H_TOT = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOT = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [10:0] H_LAST_C    = 11'(H_TOT - 1);
  localparam logic [10:0] V_LAST_C    = 11'(V_TOT - 1);
  localparam logic [10:0] H_SYNC_C    = 11'(H_SYNC);
  localparam logic [10:0] V_SYNC_C    = 11'(V_SYNC);
  localparam logic [10:0] H_START_C   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_END_C     = 11'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [10:0] V_START_C   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_END_C     = 11'(V_SYNC + V_BACK + V_VALID - 1);
  localparam logic [10:0] REQ_START_C = 11'(H_SYNC + H_BACK - PIX_LAT);
  localparam logic [10:0] REQ_END_C   = 11'(H_SYNC + H_BACK + H_VALID - 1 - PIX_LAT);

  // A request window starting before the line does is not supported.
  if (PIX_LAT > H_SYNC + H_BACK || PIX_LAT < 0) begin : g_bad_pix_lat
    $error("tft_timing_ctrl: PIX_LAT out of range");
  end

  logic [10:0] cnt_h;
  logic [10:0] cnt_v;
  logic        h_last;
  logic        v_last;
  logic        h_active;
  logic        v_active;
  logic        h_req;
  logic [15:0] rgb_src;

  assign tft_clk = sys_clk;
  assign tft_bl  = sys_rst_n;

  always_comb begin
    h_last   = (cnt_h == H_LAST_C);
    v_last   = (cnt_v == V_LAST_C);
    h_active = (cnt_h >= H_START_C) && (cnt_h <= H_END_C);
    v_active = (cnt_v >= V_START_C) && (cnt_v <= V_END_C);
    h_req    = (cnt_h >= REQ_START_C) && (cnt_h <= REQ_END_C);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_h <= '0;
      cnt_v <= '0;
    end else if (h_last) begin
      cnt_h <= '0;
      cnt_v <= v_last ? '0 : cnt_v + 11'd1;
    end else begin
      cnt_h <= cnt_h + 11'd1;
    end
  end

  // Requests lead the active area by PIX_LAT so returned data lands with tft_de.
  always_comb begin
    pix_req = 1'b0;
    pix_x   = 11'h3FF;
    pix_y   = 11'h3FF;
    if (v_active && h_req) begin
      pix_req = 1'b1;
      pix_x   = cnt_h - REQ_START_C;
      pix_y   = cnt_v - V_START_C;
    end
  end

`ifdef TFT_TEST_PATTERN_EN
  logic [15:0] bar_rgb;

  tft_test_pattern #(
    .H_START (H_SYNC + H_BACK)
  ) u_test_pattern (
    .cnt_h   (cnt_h),
    .bar_rgb (bar_rgb)
  );

  assign rgb_src = test_en ? bar_rgb : pix_data;
`else
  assign rgb_src = pix_data;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rgb         <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      tft_de      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= (cnt_h < H_SYNC_C);
      vsync       <= (cnt_v < V_SYNC_C);
      tft_de      <= h_active && v_active;
      rgb         <= (h_active && v_active) ? rgb_src : 16'h0000;
      frame_start <= (cnt_h == 11'd0) && (cnt_v == 11'd0);
    end
  end

endmodule
